// File: rtl/turf_bus_pkg.sv
// Shared TURF register-bus definitions: FSM encodings, transfer width and address byte format.
// Used by both the SURF-side master and the TURF-side register interface.
package turf_bus_pkg;
  localparam int BUS_BYTES = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_TURN  = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  typedef struct packed {
    logic                   wr;
    logic [6:0]             addr;
    logic [8*BUS_BYTES-1:0] wdata;
  } bus_req_t;

  // Address phase byte: MSB reserved as 0, low 7 bits are the register address.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {1'b0, addr};
  endfunction
endpackage

// File: rtl/turfio_bus_shifter.sv
// 32-bit byte serializer/deserializer for the TURF bus, LSB byte first.
// The 2-bit counter names the byte currently on the bus and wraps after the last byte.
module turfio_bus_shifter
  import turf_bus_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load,
  input  logic [8*BUS_BYTES-1:0] wdata,
  input  logic                   step,
  input  logic                   shift_in,
  input  logic [7:0]             din,
  output logic [7:0]             tx_byte,
  output logic [7:0]             tx_next,
  output logic [8*BUS_BYTES-1:0] rx_word,
  output logic                   last
);
  logic [8*BUS_BYTES-1:0] sh;
  logic [1:0]             cnt, cnt_nxt;

  assign cnt_nxt = cnt + 2'd1;
  assign tx_byte = sh[{cnt, 3'b000} +: 8];
  assign tx_next = sh[{cnt_nxt, 3'b000} +: 8];
  // Word as it stands once din is taken in as the final byte.
  assign rx_word = {din, sh[8*BUS_BYTES-1:8]};
  assign last    = (cnt == 2'(BUS_BYTES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= wdata;
      cnt <= '0;
    end else begin
      if (shift_in) sh  <= rx_word;
      if (step)     cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/turfio_bus_master.sv
// SURF-side master for the 8-bit TURF register bus: address byte, then 4 data bytes out
// (write) or a turnaround followed by 4 bytes in (read), then an idle gap. All outputs registered.
module turfio_bus_master
  import turf_bus_pkg::*;
#(
  parameter int TURNAROUND  = 1,
  parameter int IDLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        nCSTURF_o,
  output logic        TURF_WnR_o,
  output logic [7:0]  TURF_DIO_o,
  output logic        TURF_DIO_oe_o,
  input  logic [7:0]  TURF_DIO_i
);
  logic [2:0]  state;
  logic        wr_q;
  logic [1:0]  turn_cnt;
  logic [2:0]  gap_cnt;
  bus_req_t    req_in;
  logic        accept, turn_last, gap_last, sh_last;
  logic [7:0]  tx_byte, tx_next;
  logic [31:0] rx_word;

  assign req_in    = {wr_i, addr_i, wdata_i};
  assign turn_last = (turn_cnt == 2'(TURNAROUND - 1));
  assign gap_last  = (gap_cnt == 3'(IDLE_CYCLES - 1));
  // The edge closing the last GAP cycle is the first IDLE edge, so a held req_i
  // chains directly and back-to-back transfers see exactly IDLE_CYCLES select-high cycles.
  assign accept    = req_i && ((state == ST_IDLE && !busy_o) || (state == ST_GAP && gap_last));

  turfio_bus_shifter u_shifter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load     (accept),
    .wdata    (req_in.wdata),
    .step     (state == ST_WDATA || state == ST_RDATA),
    .shift_in (state == ST_RDATA),
    .din      (TURF_DIO_i),
    .tx_byte  (tx_byte),
    .tx_next  (tx_next),
    .rx_word  (rx_word),
    .last     (sh_last)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      wr_q          <= 1'b0;
      turn_cnt      <= '0;
      gap_cnt       <= '0;
      busy_o        <= 1'b0;
      ack_o         <= 1'b0;
      rdata_o       <= '0;
      nCSTURF_o     <= 1'b1;
      TURF_WnR_o    <= 1'b0;
      TURF_DIO_o    <= '0;
      TURF_DIO_oe_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      if (accept) begin
        state         <= ST_ADDR;
        wr_q          <= req_in.wr;
        busy_o        <= 1'b1;
        nCSTURF_o     <= 1'b0;
        TURF_WnR_o    <= req_in.wr;
        TURF_DIO_o    <= addr_byte(req_in.addr);
        TURF_DIO_oe_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (wr_q) begin
              state      <= ST_WDATA;
              TURF_DIO_o <= tx_byte;
            end else begin
              // Release the pads before the TURF can start driving.
              state         <= ST_TURN;
              turn_cnt      <= '0;
              TURF_DIO_o    <= '0;
              TURF_DIO_oe_o <= 1'b0;
            end
          end
          ST_TURN: begin
            if (turn_last) state <= ST_RDATA;
            else           turn_cnt <= turn_cnt + 2'd1;
          end
          ST_WDATA, ST_RDATA: begin
            if (sh_last) begin
              state         <= ST_GAP;
              gap_cnt       <= '0;
              ack_o         <= 1'b1;
              nCSTURF_o     <= 1'b1;
              TURF_WnR_o    <= 1'b0;
              TURF_DIO_o    <= '0;
              TURF_DIO_oe_o <= 1'b0;
              if (state == ST_RDATA) rdata_o <= rx_word;
            end else if (state == ST_WDATA) begin
              TURF_DIO_o <= tx_next;
            end
          end
          ST_GAP: begin
            if (gap_last) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_turfio_bus_master.sv
// Bench for turfio_bus_master: two instances (default timing, and TURNAROUND=3/IDLE_CYCLES=3),
// a behavioural TURF responder, per-cycle expected bus traces built from the transfer rules.
module tb_turfio_bus_master;
  localparam int TA0 = 1, IC0 = 1, TA1 = 3, IC1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2], wr[2];
  logic [6:0]  addr[2];
  logic [31:0] wdata[2];
  logic        busy[2], ack[2], ncs[2], wnr[2], oe[2];
  logic [31:0] rdata[2];
  logic [7:0]  dio[2], dio_in[2];
  logic [31:0] turf_word[2];
  logic [31:0] last_rd[2];
  int          errors = 0, checks = 0;

  always #15 clk = ~clk;

  turfio_bus_master #(.TURNAROUND(TA0), .IDLE_CYCLES(IC0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .wr_i(wr[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .busy_o(busy[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .nCSTURF_o(ncs[0]), .TURF_WnR_o(wnr[0]), .TURF_DIO_o(dio[0]),
    .TURF_DIO_oe_o(oe[0]), .TURF_DIO_i(dio_in[0]));

  turfio_bus_master #(.TURNAROUND(TA1), .IDLE_CYCLES(IC1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .wr_i(wr[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .busy_o(busy[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .nCSTURF_o(ncs[1]), .TURF_WnR_o(wnr[1]), .TURF_DIO_o(dio[1]),
    .TURF_DIO_oe_o(oe[1]), .TURF_DIO_i(dio_in[1]));

  function automatic int ta(int d); return (d == 1) ? TA1 : TA0; endfunction
  function automatic int ic(int d); return (d == 1) ? IC1 : IC0; endfunction

  // TURF responder: counts cycles after the address byte, drives the word LSB first
  // after the turnaround, junk otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_turf
    int tcnt = 0;
    always @(negedge clk) begin
      if (!ncs[g] && oe[g]) tcnt = 0;
      else if (!ncs[g])     tcnt++;
      if (!ncs[g] && !oe[g] && tcnt > ta(g) && tcnt <= ta(g) + 4)
        dio_in[g] = turf_word[g][8*(tcnt-ta(g)-1) +: 8];
      else
        dio_in[g] = 8'hA5;
    end
  end

  // Master must never drive while the select is released.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (oe[d]) begin
      checks++;
      if (ncs[d]) begin
        errors++;
        $display("FAIL oe_guard dut%0d: oe=1 while nCS=1 at %0t", d, $time);
      end
    end
  end

  initial begin
    #(30 * 40000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  typedef struct {
    bit ncs; bit wnr; bit oe; bit dchk; logic [7:0] dio; bit ack; bit busy;
  } cyc_t;
  cyc_t expq[$];

  // Expected bus trace, one entry per cycle starting with the address cycle.
  function automatic void build(int d, bit w, logic [6:0] a, logic [31:0] wd);
    expq.delete();
    expq.push_back('{1'b0, w, 1'b1, 1'b1, {1'b0, a}, 1'b0, 1'b1});
    if (w) for (int i = 0; i < 4; i++) expq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, wd[8*i +: 8], 1'b0, 1'b1});
    else   for (int i = 0; i < ta(d) + 4; i++) expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    for (int i = 0; i < ic(d); i++) expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, (i == 0), 1'b1});
    expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
  endfunction

  task automatic run_txn(input int d, input bit w, input logic [6:0] a, input logic [31:0] wd,
                         input logic [31:0] tw, input logic [31:0] exp_rd, input string nm);
    cyc_t e;
    turf_word[d] = tw;
    build(d, w, a, wd);
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    for (int k = 0; k < expq.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        req[d] = 1'b0; wr[d] = 1'($urandom); addr[d] = 7'($urandom); wdata[d] = $urandom;
      end
      e = expq[k];
      checks++;
      if (ncs[d] !== e.ncs || wnr[d] !== e.wnr || oe[d] !== e.oe || ack[d] !== e.ack ||
          busy[d] !== e.busy || (e.dchk && dio[d] !== e.dio)) begin
        errors++;
        $display("FAIL %s dut%0d cycle N+%0d: got ncs=%b wnr=%b oe=%b dio=%h ack=%b busy=%b want ncs=%b wnr=%b oe=%b dio=%h ack=%b busy=%b",
                 nm, d, k + 1, ncs[d], wnr[d], oe[d], dio[d], ack[d], busy[d],
                 e.ncs, e.wnr, e.oe, e.dio, e.ack, e.busy);
      end
      if (e.ack) chk({nm, "_rdata"}, 64'(rdata[d]), 64'(exp_rd));
    end
    last_rd[d] = w ? last_rd[d] : tw;
  endtask

  typedef struct {
    int d; bit w; logic [6:0] a; logic [31:0] wd; logic [31:0] tw; logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int acks, c_ack1, c_ack2, c_addr2, hi_run, dbl;
    bit prev_ack;
    logic [31:0] rd2;

    tbl[0] = '{0, 1'b1, 7'h05, 32'h12345678, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{0, 1'b0, 7'h7F, 32'h0,        32'h80000001, 32'h80000001};
    tbl[2] = '{0, 1'b0, 7'h00, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    tbl[3] = '{1, 1'b0, 7'h3C, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4] = '{1, 1'b1, 7'h7F, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D};
    tbl[5] = '{0, 1'b1, 7'h00, 32'h00000000, 32'h0,        32'h00000000};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; wr[d] = 0; addr[d] = 0; wdata[d] = 0; turf_word[d] = 0; last_rd[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_state_dut%0d", d),
          64'({ncs[d], wnr[d], oe[d], dio[d], busy[d], ack[d], rdata[d]}), 64'({1'b1, 44'h0}));
    rst_n = 1'b1;

    // Reset during RDATA byte 2 aborts without ack; a request held through reset waits for release.
    turf_word[0] = 32'h11223344;
    @(negedge clk); req[0] = 1; wr[0] = 0; addr[0] = 7'h0A;
    @(posedge clk);
    @(negedge clk); req[0] = 0;
    repeat (TA0 + 3) @(negedge clk);
    chk("in_rdata_byte2", 64'({ncs[0], oe[0], busy[0]}), 64'(3'b001));
    rst_n = 1'b0;
    #1;
    chk("async_abort", 64'({ncs[0], wnr[0], oe[0], busy[0], ack[0]}), 64'(5'b10000));
    req[1] = 1; wr[1] = 1; addr[1] = 7'h40; wdata[1] = 32'h55AA55AA;
    repeat (3) begin
      @(negedge clk);
      chk("held_in_reset", 64'({ack[0], ncs[0], ncs[1], busy[1]}), 64'(4'b0110));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_accept_after_rst", 64'({ncs[1], oe[1], dio[1]}), 64'({1'b0, 1'b1, 8'h40}));
    chk("no_ack_after_abort", 64'({ack[0], busy[0], rdata[0]}), 64'h0);
    req[1] = 0;
    repeat (10) @(negedge clk);
    chk("write_after_rst_done", 64'({busy[1], rdata[1]}), 64'h0);
    run_txn(0, 1'b0, 7'h0A, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, "read_after_rst");

    // Held req_i: write then read back to back on the IDLE_CYCLES=3 instance.
    turf_word[1] = 32'h0BADF00D;
    @(negedge clk); req[1] = 1; wr[1] = 1; addr[1] = 7'h11; wdata[1] = 32'hA1B2C3D4;
    @(posedge clk);
    acks = 0; c_ack1 = -1; c_ack2 = -1; c_addr2 = -1; hi_run = 0; dbl = 0; prev_ack = 0; rd2 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin wr[1] = 0; addr[1] = 7'h22; wdata[1] = 0; end
      if (ack[1]) begin
        if (prev_ack) dbl++;
        acks++;
        if (acks == 1) c_ack1 = c;
        else begin c_ack2 = c; rd2 = rdata[1]; end
      end
      prev_ack = ack[1];
      if (c_ack1 > 0 && c_addr2 < 0) begin
        if (ncs[1]) hi_run++;
        else begin
          c_addr2 = c;
          chk("b2b_addr2", 64'({wnr[1], oe[1], dio[1]}), 64'({1'b0, 1'b1, 8'h22}));
          req[1] = 0;
        end
      end
    end
    chk("b2b_ack_count", 64'(acks), 64'(2));
    chk("b2b_single_pulse", 64'(dbl), 64'(0));
    chk("b2b_ncs_high", 64'(hi_run), 64'(IC1));
    chk("b2b_ack1_cycle", 64'(c_ack1), 64'(6));
    chk("b2b_addr2_cycle", 64'(c_addr2), 64'(6 + IC1));
    chk("b2b_ack2_cycle", 64'(c_ack2), 64'(6 + IC1 + 1 + TA1 + 4));
    chk("b2b_rdata", 64'(rd2), 64'(32'h0BADF00D));
    chk("b2b_idle", 64'(busy[1]), 64'(0));
    last_rd[1] = 32'h0BADF00D;

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].tw, tbl[i].exp_rd,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      int d; bit w; logic [31:0] tw;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom);
      tw = $urandom;
      run_txn(d, w, 7'($urandom), $urandom, tw, w ? last_rd[d] : tw, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/turfio_bus_master.md
TURFIO_BUS_MASTER -- requirements
Module: turfio_bus_master

Interface
REQ-001 SHALL have parameter TURNAROUND, default 1, bus-idle cycles between address byte and first read byte (1..3).
REQ-002 SHALL have parameter IDLE_CYCLES, default 1, minimum cycles with nCSTURF_o high between transactions (1..7).
REQ-003 clk_i  input  1  33 MHz TURF register-bus clock; the only clock, all logic on rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  transaction request; level, sampled only when busy_o low.
REQ-006 wr_i  input  1  1 = write, 0 = read; captured with req_i.
REQ-007 addr_i  input  7  register address; captured with req_i.
REQ-008 wdata_i  input  32  write data; captured with req_i.
REQ-009 busy_o  output  1  high from the cycle after acceptance through the last gap cycle.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  32  read data; valid when ack_o high for a read, held until the next read ack.
REQ-012 nCSTURF_o  output  1  active-low bus select to TURF.
REQ-013 TURF_WnR_o  output  1  bus direction, 1 = master writes.
REQ-014 TURF_DIO_o  output  8  bus data driven by master.
REQ-015 TURF_DIO_oe_o  output  1  output enable for the TURF_DIO pad tristate.
REQ-016 TURF_DIO_i  input  8  bus data from pad.

Function
REQ-017 All bus outputs, busy_o, ack_o and rdata_o SHALL be driven from registers; no combinational input-to-output paths.
REQ-018 FSM states SHALL be IDLE, ADDR, WDATA, TURN, RDATA, GAP.
REQ-019 IDLE: if req_i=1 and busy_o=0 at an edge, capture wr/addr/wdata and enter ADDR; otherwise remain.
REQ-020 ADDR (1 cycle): nCSTURF_o=0, TURF_WnR_o=wr, TURF_DIO_o={1'b0,addr}, oe=1; go to WDATA if wr, else TURN.
REQ-021 WDATA (4 cycles): nCSTURF_o=0, WnR=1, oe=1, TURF_DIO_o = wdata bytes 0,1,2,3 (LSB first); then GAP.
REQ-022 TURN (TURNAROUND cycles): nCSTURF_o=0, WnR=0, oe=0; then RDATA.
REQ-023 RDATA (4 cycles): nCSTURF_o=0, WnR=0, oe=0; TURF_DIO_i sampled at the end of each cycle into bytes 0..3 LSB first; then GAP.
REQ-024 GAP (IDLE_CYCLES cycles): nCSTURF_o=1, WnR=0, oe=0, TURF_DIO_o=0; ack_o=1 in the first GAP cycle only; rdata_o updated in that same cycle for reads; then IDLE.
REQ-025 Write latency: req accepted at edge N -> ADDR cycle N+1, data N+2..N+5, ack N+6; read (TURNAROUND=1): ADDR N+1, TURN N+2, data N+3..N+6, ack N+7.
REQ-026 oe SHALL never be 1 in any TURN, RDATA or GAP cycle; the master never drives during a cycle the TURF may drive.
REQ-027 req_i while busy_o=1 SHALL be ignored; a held req_i is accepted on the first IDLE edge, so back-to-back transactions are separated by exactly IDLE_CYCLES select-high cycles.
REQ-028 Write transactions SHALL leave rdata_o unchanged.
REQ-029 Byte counter SHALL be 2 bits and wrap 3->0 on exit from WDATA/RDATA.

Reset
REQ-030 rst_n_i low SHALL asynchronously force IDLE, nCSTURF_o=1, WnR=0, oe=0, TURF_DIO_o=0, busy_o=0, ack_o=0, rdata_o=0, captured registers 0.
REQ-031 Reset mid-transaction SHALL abort without ack_o; the first request after deassertion is accepted no earlier than the first edge with rst_n_i high.

Structure
REQ-032 State encodings, the byte count (4) and the address byte format SHALL live in a shared package turf_bus_pkg, also used by the TURF-side register interface.
REQ-033 One sub-module, turfio_bus_shifter (32-bit byte serializer/deserializer with 2-bit counter), SHALL be instantiated; the FSM remains in the top.

Verification
REQ-034 Write addr 0x05, data 0x12345678 -> DIO 0x05,0x78,0x56,0x34,0x12 on consecutive cycles with nCS low and oe=1; ack at N+6.
REQ-035 Read addr 0x0A with TURF model returning 0xDEADBEEF LSB first -> oe=0 from N+2, ack at N+7 with rdata_o=0xDEADBEEF.
REQ-036 req_i held high for write then read, IDLE_CYCLES=3 -> exactly 3 nCS-high cycles between transactions and two single-cycle ack_o pulses.
REQ-037 rst_n_i asserted during RDATA byte 2 -> immediate nCS high, oe=0, busy 0, no ack; next read completes normally.
REQ-038 TURNAROUND=3 read -> 3 TURN cycles with oe=0, ack at N+9; assertion checks oe never 1 outside ADDR/WDATA.
